// File: rtl/sram_responder_if.sv
// Backdoor host port of sram_responder, used to preload and inspect the array.
// Handshake: a request transfers on a clk edge with bd_valid && bd_ready; the requester holds it until then. A read returns bd_rdata with a one-cycle bd_rvalid pulse.
interface sram_responder_if #(parameter int ADDR_W = 12);
  logic              bd_valid;
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [15:0]       bd_wdata;
  logic              bd_ready;
  logic              bd_rvalid;
  logic [15:0]       bd_rdata;

  modport master (output bd_valid, bd_we, bd_addr, bd_wdata,
                  input  bd_ready, bd_rvalid, bd_rdata);
  modport slave  (input  bd_valid, bd_we, bd_addr, bd_wdata,
                  output bd_ready, bd_rvalid, bd_rdata);
endinterface

// File: rtl/sram_responder.sv
// On-chip stand-in for a 16-bit async SRAM: byte-lane writes, zero-latency reads, clear sweep, backdoor, counters.
// Optional access-error detection is built when SRAM_RESP_ACCESS_ERR_EN is defined; otherwise err is tied low.
module sram_responder #(
  parameter int ADDR_W         = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_SRAM_WE_N,
  input  logic        i_SRAM_CE_N,
  input  logic        i_SRAM_OE_N,
  input  logic        i_SRAM_LB_N,
  input  logic        i_SRAM_UB_N,
  input  logic [19:0] i_SRAM_ADDR,
  inout  wire  [15:0] io_SRAM_DQ,
  sram_responder_if.slave bd,
  output logic        busy,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic        err
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [15:0]       mem [DEPTH];

  logic [ADDR_W-1:0] a;
  logic              serve;
  logic              bus_rd;
  logic              bus_wr;
  logic              bd_acc;
  logic              bd_rd_acc;
  logic              bd_wr_acc;
  logic [15:0]       rd_word;
  logic [15:0]       rd_val;
  logic              dq_drive;
  logic              unused_addr_hi;

  assign a              = i_SRAM_ADDR[ADDR_W-1:0];
  assign unused_addr_hi = ^i_SRAM_ADDR[19:ADDR_W];
  assign serve          = (state == ST_SERVE);
  assign bus_rd         = !i_SRAM_CE_N && !i_SRAM_OE_N && i_SRAM_WE_N;
  assign bus_wr         = !i_SRAM_CE_N && !i_SRAM_WE_N;

  // Bus writes own the array port; the backdoor waits a cycle behind them.
  assign bd.bd_ready = serve && !bus_wr;
  assign bd_acc      = bd.bd_valid && bd.bd_ready;
  assign bd_rd_acc   = bd_acc && !bd.bd_we;
  assign bd_wr_acc   = bd_acc && bd.bd_we;

  assign rd_word    = mem[a];
  assign rd_val     = {i_SRAM_UB_N ? 8'h00 : rd_word[15:8],
                       i_SRAM_LB_N ? 8'h00 : rd_word[7:0]};
  assign dq_drive   = serve && bus_rd && !rst;
  assign io_SRAM_DQ = dq_drive ? rd_val : 16'hzzzz;

  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET) begin
        state <= ST_CLEAR;
        busy  <= 1'b1;
      end else begin
        state <= ST_SERVE;
        busy  <= 1'b0;
      end
      clr_ptr      <= '0;
      bd.bd_rvalid <= 1'b0;
      bd.bd_rdata  <= 16'h0000;
      wr_count     <= 16'h0000;
      rd_count     <= 16'h0000;
    end else begin
      bd.bd_rvalid <= bd_rd_acc;
      if (bd_rd_acc) bd.bd_rdata <= mem[bd.bd_addr];
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_IDX) begin
            state <= ST_SERVE;
            busy  <= 1'b0;
          end
        end
        ST_SERVE: begin
          if (bus_wr && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'h0001;
          if (bus_rd && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'h0001;
        end
        default: state <= ST_SERVE;
      endcase
    end
  end

  // Array has no reset of its own; only the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem[clr_ptr] <= 16'h0000;
      end else if (bus_wr) begin
        if (!i_SRAM_UB_N) mem[a][15:8] <= io_SRAM_DQ[15:8];
        if (!i_SRAM_LB_N) mem[a][7:0]  <= io_SRAM_DQ[7:0];
      end else if (bd_wr_acc) begin
        mem[bd.bd_addr] <= bd.bd_wdata;
      end
    end
  end

`ifdef SRAM_RESP_ACCESS_ERR_EN
  logic        overlap;
  logic        prev_overlap;
  logic [19:0] prev_addr;

  assign overlap = !i_SRAM_CE_N && !i_SRAM_WE_N && !i_SRAM_OE_N && !(i_SRAM_LB_N && i_SRAM_UB_N);

  always_ff @(posedge clk) begin
    if (rst) begin
      err          <= 1'b0;
      prev_overlap <= 1'b0;
      prev_addr    <= 20'h00000;
    end else begin
      if ((busy && !i_SRAM_CE_N && (!i_SRAM_WE_N || !i_SRAM_OE_N)) ||
          (overlap && prev_overlap && (i_SRAM_ADDR == prev_addr)))
        err <= 1'b1;
      prev_overlap <= overlap;
      prev_addr    <= i_SRAM_ADDR;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
